// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state, ALU encodings and instruction field positions
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_BEQZ = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int D_MSB  = 11;
  localparam int D_LSB  = 8;
  localparam int S_MSB  = 7;
  localparam int S_LSB  = 4;
  localparam int T_MSB  = 3;
  localparam int T_LSB  = 0;
  localparam int K_MSB  = 7;
  localparam int K_LSB  = 0;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational instruction-register decoder
// Fields an opcode does not use are held at zero so the datapath sees a quiet bus.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  ra1_o,
  output logic [3:0]  ra2_o,
  output logic [3:0]  wa_o,
  output logic [7:0]  imm_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_ctrl_o,
  output logic        reg_we_o,
  output logic        is_beqz_o,
  output logic        is_jmp_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  logic [3:0] op, f_d, f_s, f_t;
  logic [7:0] f_k;

  assign op  = ir_i[OP_MSB:OP_LSB];
  assign f_d = ir_i[D_MSB:D_LSB];
  assign f_s = ir_i[S_MSB:S_LSB];
  assign f_t = ir_i[T_MSB:T_LSB];
  assign f_k = ir_i[K_MSB:K_LSB];

  always_comb begin
    ra1_o        = '0;
    ra2_o        = '0;
    wa_o         = '0;
    imm_o        = '0;
    alu_src_o    = 1'b0;
    alu_ctrl_o   = ALU_ADD;
    reg_we_o     = 1'b0;
    is_beqz_o    = 1'b0;
    is_jmp_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        ra1_o      = f_s;
        ra2_o      = f_t;
        wa_o       = f_d;
        alu_ctrl_o = op[1:0];
        reg_we_o   = 1'b1;
      end
      OP_ADDI: begin
        ra1_o     = f_d;
        wa_o      = f_d;
        imm_o     = f_k;
        alu_src_o = 1'b1;
        reg_we_o  = 1'b1;
      end
      // Zero test is done by the ALU as rd + 0
      OP_BEQZ: begin
        ra1_o     = f_d;
        alu_src_o = 1'b1;
        is_beqz_o = 1'b1;
      end
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - fetch/execute controller owning FSM, PC, IR and retired counter
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [15:0]      imem_rdata,
  output logic [3:0]       RA1,
  output logic [3:0]       RA2,
  output logic [3:0]       WA,
  output logic [7:0]       immediate,
  output logic             write_enable,
  output logic             ALUsrc,
  output logic [1:0]       ALUControl,
  input  logic             Zero,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic dec_we, dec_beqz, dec_jmp, dec_halt, dec_illegal;
  logic [PC_W-1:0] k_sx;

  cpu_decode u_decode (
    .ir_i         (ir_q),
    .ra1_o        (RA1),
    .ra2_o        (RA2),
    .wa_o         (WA),
    .imm_o        (immediate),
    .alu_src_o    (ALUsrc),
    .alu_ctrl_o   (ALUControl),
    .reg_we_o     (dec_we),
    .is_beqz_o    (dec_beqz),
    .is_jmp_o     (dec_jmp),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal)
  );

  assign k_sx = PC_W'($signed(ir_q[K_MSB:K_LSB]));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          ret_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_beqz && Zero) begin
          pc_d = pc_q + PC_W'(1) + k_sx;
        end else if (dec_jmp) begin
          pc_d = PC_W'(ir_q[K_MSB:K_LSB]);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        if (ret_q != '1) begin
          ret_d = ret_q + CNT_W'(1);
        end
        state_d = dec_halt ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign write_enable = (state_q == ST_EXEC) && dec_we;
  assign illegal      = (state_q == ST_EXEC) && dec_illegal;
  assign halted       = (state_q == ST_HALT);
  assign retired      = ret_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl against an instruction-level model
module tb_cpu_ctrl;

  logic        CLK, RST, start;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  immediate;
  logic        write_enable, ALUsrc, Zero, halted, illegal;
  logic [1:0]  ALUControl;
  logic [15:0] retired;

  cpu_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate), .write_enable(write_enable),
    .ALUsrc(ALUsrc), .ALUControl(ALUControl), .Zero(Zero),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    bit          we;
    logic [3:0]  wa;
    logic [15:0] val;
    bit          ill;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  bit          exec_chk = 0;
  bit          sb_en = 0;
  logic [15:0] imem [256];
  logic [15:0] m_rf [16];
  int          exp_ret;

  // environment: register file and ALU driven by the controller
  logic [15:0] rf [16];
  logic [15:0] alu_a, alu_b, alu_res;
  logic        rf_clr = 1'b0;
  int          wr_cnt = 0;
  int          valid_mode = 0;
  logic        rnd_bit = 1'b0;

  assign imem_rdata = imem[imem_addr];
  assign imem_valid = (valid_mode == 2) ? rnd_bit : (valid_mode == 1);

  always_comb begin
    alu_a = rf[RA1];
    alu_b = ALUsrc ? {8'h00, immediate} : rf[RA2];
    case (ALUControl)
      2'b00:   alu_res = alu_a + alu_b;
      2'b01:   alu_res = alu_a - alu_b;
      2'b10:   alu_res = alu_a & alu_b;
      default: alu_res = alu_a | alu_b;
    endcase
  end
  assign Zero = (alu_res == 16'h0000);

  always @(posedge CLK) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
    end else if (write_enable) begin
      rf[WA] <= alu_res;
    end
    if (write_enable) wr_cnt <= wr_cnt + 1;
  end

  initial forever begin
    @(posedge CLK);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: every accepted fetch pops one expected instruction, checked in its EXEC cycle
  initial forever begin
    @(negedge CLK);
    if (!sb_en) begin
      exec_chk = 0;
    end else if (exec_chk) begin
      exec_chk = 0;
      chk("exec_we", write_enable, cur.we);
      chk("exec_illegal", illegal, cur.ill);
      if (cur.we && write_enable) begin
        chk("exec_wa", WA, cur.wa);
        chk("exec_data", alu_res, cur.val);
      end
    end else begin
      chk("quiet_we", write_enable, 0);
      chk("quiet_illegal", illegal, 0);
      if (imem_req && imem_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr %0h expected none", imem_addr);
        end else begin
          cur = exp_q.pop_front();
          chk("fetch_addr", imem_addr, cur.addr);
          exec_chk = 1;
        end
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  // instruction-level reference: walk the program, recording each instruction's effects
  task automatic model_run();
    int pc, steps;
    bit done;
    logic [15:0] ins, a, b;
    logic [3:0] op, d, s, t;
    logic [7:0] k;
    exp_t e;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    exp_q.delete();
    pc = 0; steps = 0; done = 0;
    while (!done && steps < 300) begin
      ins = imem[pc];
      op = ins[15:12]; d = ins[11:8]; s = ins[7:4]; t = ins[3:0]; k = ins[7:0];
      e.addr = pc[7:0]; e.we = 0; e.wa = 0; e.val = 0; e.ill = 0;
      steps++;
      if (op <= 4'h3) begin
        a = m_rf[s]; b = m_rf[t];
        e.val = (op == 0) ? a + b : (op == 1) ? a - b : (op == 2) ? (a & b) : (a | b);
        e.we = 1; e.wa = d; m_rf[d] = e.val;
        pc = (pc + 1) % 256;
      end else if (op == 4'h4) begin
        e.val = m_rf[d] + {8'h00, k};
        e.we = 1; e.wa = d; m_rf[d] = e.val;
        pc = (pc + 1) % 256;
      end else if (op == 4'h8) begin
        if (m_rf[d] == 0) pc = (pc + 1 + int'($signed(k))) & 255;
        else pc = (pc + 1) % 256;
      end else if (op == 4'h9) begin
        pc = int'(k);
      end else if (op == 4'hF) begin
        done = 1;
      end else begin
        e.ill = 1;
        pc = (pc + 1) % 256;
      end
      exp_q.push_back(e);
    end
    exp_ret = steps;
  endtask

  task automatic start_pulse();
    @(posedge CLK); #1;
    start = 1'b1; rf_clr = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; rf_clr = 1'b0;
  endtask

  task automatic finish_run(input string name, input int budget, output int cycles);
    int mism;
    cycles = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge CLK); #1;
      cycles = n;
      if (halted) break;
    end
    if (!halted) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got halted=0 expected halted=1 within %0d cycles", name, budget);
    end
    @(negedge CLK); #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_retired"}, retired, exp_ret);
    chk({name, "_halted"}, halted, 1);
    mism = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== m_rf[i]) mism++;
    chk({name, "_regfile"}, mism, 0);
  endtask

  task automatic run_prog(input string name, input int vmode, output int cycles);
    model_run();
    valid_mode = vmode;
    start_pulse();
    finish_run(name, 3000, cycles);
  endtask

  task automatic gen_random();
    int len, kind, pc;
    clear_imem();
    len = $urandom_range(6, 20);
    for (pc = 0; pc < len; pc++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1, 2, 3: imem[pc] = {4'(kind), 1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)};
        4: imem[pc] = {4'h4, 1'b0, 3'($urandom), 8'($urandom)};
        5: imem[pc] = {4'h8, 1'b0, 3'($urandom), 8'($urandom_range(1, 3))};
        6: imem[pc] = {4'h9, 4'h0, 8'(pc + $urandom_range(1, 4))};
        default: imem[pc] = {4'($urandom_range(5, 7)), 12'($urandom)};
      endcase
    end
  endtask

  task automatic test_stall();
    bit found;
    int cyc;
    clear_imem();
    imem[0] = 16'h4105; imem[1] = 16'hF000;
    model_run();
    valid_mode = 1;
    start_pulse();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK); #1;
      if (imem_req && imem_addr == 8'd1) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL stall_reach: got no fetch of addr 1 expected one within 20 cycles");
    end
    valid_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 1);
      chk("stall_we", write_enable, 0);
    end
    start = 1'b0;
    valid_mode = 1;
    finish_run("stall", 50, cyc);
  endtask

  task automatic test_reset_exec();
    int wr0;
    sb_en = 0;
    clear_imem();
    imem[0] = 16'h0123;
    valid_mode = 1;
    start_pulse();
    @(posedge CLK); #1;
    chk("rstx_we_before", write_enable, 1);
    wr0 = wr_cnt;
    RST = 1'b1;
    #1;
    chk("rstx_we", write_enable, 0);
    chk("rstx_req", imem_req, 0);
    chk("rstx_addr", imem_addr, 0);
    chk("rstx_dec", {RA1, RA2, WA, immediate, ALUsrc, ALUControl}, 0);
    chk("rstx_flags", {halted, illegal}, 0);
    chk("rstx_retired", retired, 0);
    @(posedge CLK); #1;
    chk("rstx_nowrite", wr_cnt, wr0);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rstx_idle_req", imem_req, 0);
    chk("rstx_idle_halted", halted, 0);
  endtask

  initial begin
    int cyc;
    RST = 1'b1; start = 1'b0;
    clear_imem();
    #2;
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_flags", {write_enable, halted, illegal}, 0);
    chk("reset_dec", {RA1, RA2, WA, immediate, ALUsrc, ALUControl}, 0);
    chk("reset_retired", retired, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_req", imem_req, 0);
    sb_en = 1;

    imem[0] = 16'h4105; imem[1] = 16'hF000;
    run_prog("addi_halt", 1, cyc);
    chk("addi_halt_latency", cyc, 4);

    clear_imem();
    imem[0] = 16'h4203; imem[1] = 16'h1322; imem[2] = 16'h8304;
    imem[3] = 16'h4301; imem[4] = 16'h4301; imem[5] = 16'h4301; imem[6] = 16'h4301;
    run_prog("beqz_taken", 1, cyc);

    clear_imem();
    imem[0] = 16'h810E; imem[8'h0F] = 16'h4101; imem[8'h10] = 16'h90FF; imem[8'hFF] = 16'h5000;
    run_prog("jmp_wrap", 2, cyc);

    clear_imem();
    imem[0] = 16'h9020; imem[8'h20] = 16'h80EF;
    run_prog("beqz_back", 2, cyc);

    clear_imem();
    imem[0] = 16'h7000;
    run_prog("illegal", 1, cyc);

    test_stall();

    for (int r = 0; r < 8; r++) begin
      gen_random();
      run_prog("random", 2, cyc);
    end

    test_reset_exec();
    exp_q.delete();
    sb_en = 1;
    clear_imem();
    imem[0] = 16'h4107; imem[1] = 16'h3011; imem[2] = 16'hF000;
    run_prog("after_reset", 2, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
